// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, funct, ALU select, alu_op and control state encodings shared by the multicycle CPU
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's alu_op and the instruction funct field to the ALU select code
module alu_decoder
  import cpu_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel
);
  logic [2:0] funct_sel;
  always_comb begin
    funct_sel = funct == FUNCT_SUB ? ALU_SUB :
                funct == FUNCT_AND ? ALU_AND :
                funct == FUNCT_OR  ? ALU_OR  :
                funct == FUNCT_SLT ? ALU_SLT : ALU_ADD;
    alu_sel = alu_op == ALUOP_SUB   ? ALU_SUB :
              alu_op == ALUOP_FUNCT ? funct_sel : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: instruction sequencer driving all datapath enables and mux selects
module multicycle_control
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic [3:0] state
);
  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    pc_write, branch, ir_write_s, mem_write_s, reg_write_s;
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                            op == OP_RTYPE ? S_EXECUTE :
                            op == OP_BEQ   ? S_BRANCH :
                            op == OP_ADDI  ? S_ADDIEXEC :
                            op == OP_J     ? S_JUMP : S_FETCH;
      S_MEMADR:   state_d = op == OP_LW ? S_MEMRD : op == OP_SW ? S_MEMWR : S_FETCH;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end
  always_comb begin
    alu_op      = ALUOP_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_s = 1'b1;
        pc_write   = 1'b1;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD:    iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:   reg_write_s = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  // write strobes are masked by reset so an aborted instruction commits nothing
  assign ir_write  = ir_write_s & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign pc_en     = (pc_write | (branch & zero)) & ~reset;
  assign state     = state_q;
  alu_decoder u_alu_decoder (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_sel (alu_sel)
  );
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven check of state sequencing and per-state control outputs
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset, zero;
  logic [5:0] op, funct;
  logic [2:0] alu_sel;
  logic       alu_src_a, iord, reg_dst, mem_to_reg, ir_write, mem_write, reg_write, pc_en;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [18:0] exp;
  } vec_t;
  vec_t vecs[$];
  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alu_sel    (alu_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .iord       (iord),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .state      (state)
  );
  always #5 clk = ~clk;
  // en = {iord, reg_dst, mem_to_reg, ir_write, mem_write, reg_write, pc_en}
  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [3:0] s, input logic [2:0] a, input logic sa,
                     input logic [1:0] sb, input logic [1:0] ps, input logic [6:0] en);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z;
    v.exp = {s, a, sa, sb, ps, en};
    vecs.push_back(v);
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  initial begin
    logic [18:0] got;
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_enables", {28'd0, ir_write, mem_write, reg_write, pc_en}, 32'd0);
    // reset held with lw pending: stays in FETCH, strobes masked
    add(1, 6'b100011, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0000000);
    // lw: 0,1,2,3,4
    add(0, 6'b100011, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b100011, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b100011, 6'b000000, 0, 4'd2,  3'b010, 1, 2'b10, 2'b00, 7'b0000000);
    add(0, 6'b100011, 6'b000000, 0, 4'd3,  3'b010, 0, 2'b00, 2'b00, 7'b1000000);
    add(0, 6'b100011, 6'b000000, 0, 4'd4,  3'b010, 0, 2'b00, 2'b00, 7'b0010010);
    // R-type sub
    add(0, 6'b000000, 6'b100010, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000000, 6'b100010, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b100010, 0, 4'd6,  3'b110, 1, 2'b00, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b100010, 0, 4'd7,  3'b010, 0, 2'b00, 2'b00, 7'b0100010);
    // R-type slt
    add(0, 6'b000000, 6'b101010, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000000, 6'b101010, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b101010, 0, 4'd6,  3'b111, 1, 2'b00, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b101010, 0, 4'd7,  3'b010, 0, 2'b00, 2'b00, 7'b0100010);
    // R-type and / or / add in EXECUTE only
    add(0, 6'b000000, 6'b100100, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000000, 6'b100100, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b100100, 0, 4'd6,  3'b000, 1, 2'b00, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b100101, 0, 4'd7,  3'b010, 0, 2'b00, 2'b00, 7'b0100010);
    add(0, 6'b000000, 6'b100101, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000000, 6'b100101, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b100101, 0, 4'd6,  3'b001, 1, 2'b00, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b100000, 0, 4'd7,  3'b010, 0, 2'b00, 2'b00, 7'b0100010);
    // beq taken then not taken
    add(0, 6'b000100, 6'b000000, 1, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000100, 6'b000000, 1, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000100, 6'b000000, 1, 4'd8,  3'b110, 1, 2'b00, 2'b01, 7'b0000001);
    add(0, 6'b000100, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000100, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000100, 6'b000000, 0, 4'd8,  3'b110, 1, 2'b00, 2'b01, 7'b0000000);
    // illegal op: FETCH, DECODE, FETCH
    add(0, 6'b111111, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b111111, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    // R-type with unknown funct
    add(0, 6'b000000, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000000, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b000000, 0, 4'd6,  3'b010, 1, 2'b00, 2'b00, 7'b0000000);
    add(0, 6'b000000, 6'b000000, 0, 4'd7,  3'b010, 0, 2'b00, 2'b00, 7'b0100010);
    // addi
    add(0, 6'b001000, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b001000, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b001000, 6'b000000, 0, 4'd9,  3'b010, 1, 2'b10, 2'b00, 7'b0000000);
    add(0, 6'b001000, 6'b000000, 0, 4'd10, 3'b010, 0, 2'b00, 2'b00, 7'b0000010);
    // sw aborted by reset in MEMWR
    add(0, 6'b101011, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b101011, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b101011, 6'b000000, 0, 4'd2,  3'b010, 1, 2'b10, 2'b00, 7'b0000000);
    add(1, 6'b101011, 6'b000000, 0, 4'd5,  3'b010, 0, 2'b00, 2'b00, 7'b1000000);
    // j after reset: 0,1,11 then back to FETCH
    add(0, 6'b000010, 6'b000000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    add(0, 6'b000010, 6'b000000, 0, 4'd1,  3'b010, 0, 2'b11, 2'b00, 7'b0000000);
    add(0, 6'b000010, 6'b000000, 0, 4'd11, 3'b010, 0, 2'b00, 2'b10, 7'b0000001);
    add(0, 6'b000000, 6'b100000, 0, 4'd0,  3'b010, 0, 2'b01, 2'b00, 7'b0001001);
    foreach (vecs[i]) begin
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
      #1;
      got = {state, alu_sel, alu_src_a, alu_src_b, pc_src,
             iord, reg_dst, mem_to_reg, ir_write, mem_write, reg_write, pc_en};
      check($sformatf("vec%0d", i), {13'd0, got}, {13'd0, vecs[i].exp});
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
